// File: rtl/ecall_service_unit.sv
// Services RISC-V ecall instructions: board I/O (LEDs, 7-segment, halt), switch
// reads confirmed by a push button, and results returned to x10 through the ecall write port.
module ecall_service_unit #(
  parameter int SW_WIDTH    = 16,
  parameter int LED_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ecall_req,
  input  logic [31:0]          a7,
  input  logic [31:0]          a0,
  input  logic                 reg_write_pending,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic                 btn_confirm,
  output logic [31:0]          ecallData,
  output logic                 ecallWrite,
  output logic                 stall,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [31:0]          seg_data,
  output logic                 halted
);

  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
  localparam logic [31:0] SVC_READ_UNS  = 32'd12;
  localparam logic [31:0] SVC_PRINT_HEX = 32'd34;

  typedef enum logic [2:0] {
    S_IDLE, S_DISPATCH, S_WAIT_IN, S_WRITE, S_HALT
  } state_t;

  state_t                r_state, w_next;
  logic [31:0]           r_svc, r_arg;
  logic                  r_unsigned;
  logic [31:0]           r_ecall_data;
  logic [LED_WIDTH-1:0]  r_led;
  logic [31:0]           r_seg;
  logic                  r_halted;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_sync_q;
  logic                  w_confirm;
  logic [31:0]           w_sw_sext, w_sw_zext;

  // Button is asynchronous: synchronize, then take the rising edge as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync   <= '0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], btn_confirm};
      r_sync_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_confirm = r_sync[SYNC_STAGES-1] & ~r_sync_q;
  assign w_sw_sext = 32'($signed(sw_in));
  assign w_sw_zext = 32'(sw_in);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (ecall_req) w_next = S_DISPATCH;
      S_DISPATCH: begin
        case (r_svc)
          SVC_READ_INT, SVC_READ_UNS: w_next = S_WAIT_IN;
          SVC_EXIT:                   w_next = S_HALT;
          default:                    w_next = S_IDLE;
        endcase
      end
      S_WAIT_IN:  if (w_confirm) w_next = S_WRITE;
      // Pipeline regWrite owns the register file port; hold until it frees up.
      S_WRITE:    if (!reg_write_pending) w_next = S_IDLE;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_svc        <= '0;
      r_arg        <= '0;
      r_unsigned   <= 1'b0;
      r_ecall_data <= '0;
      r_led        <= '0;
      r_seg        <= '0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ecall_req) begin
            r_svc <= a7;
            r_arg <= a0;
          end
        end
        S_DISPATCH: begin
          case (r_svc)
            SVC_PRINT_INT: r_seg      <= r_arg;
            SVC_PRINT_HEX: r_led      <= r_arg[LED_WIDTH-1:0];
            SVC_READ_INT:  r_unsigned <= 1'b0;
            SVC_READ_UNS:  r_unsigned <= 1'b1;
            SVC_EXIT:      r_halted   <= 1'b1;
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          if (w_confirm) r_ecall_data <= r_unsigned ? w_sw_zext : w_sw_sext;
        end
        default: ;
      endcase
    end
  end

  assign ecallData  = r_ecall_data;
  assign ecallWrite = (r_state == S_WRITE);
  assign stall      = ecall_req | (r_state != S_IDLE);
  assign led_out    = r_led;
  assign seg_data   = r_seg;
  assign halted     = r_halted;

endmodule

// File: tb/tb_ecall_service_unit.sv
// Bench for ecall_service_unit: vector table, randomized services against a
// service-level model, and hand sequences for reset, exit and early button pulses.
module tb_ecall_service_unit;
  localparam int SW = 16;
  localparam int LW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ecall_req = 1'b0;
  logic [31:0]   a7 = '0, a0 = '0;
  logic          reg_write_pending = 1'b0;
  logic [SW-1:0] sw_in = '0;
  logic          btn_confirm = 1'b0;
  logic [31:0]   ecallData;
  logic          ecallWrite, stall, halted;
  logic [LW-1:0] led_out;
  logic [31:0]   seg_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_seg, m_led, m_data;

  ecall_service_unit #(.SW_WIDTH(SW), .LED_WIDTH(LW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .ecall_req(ecall_req), .a7(a7), .a0(a0),
    .reg_write_pending(reg_write_pending), .sw_in(sw_in), .btn_confirm(btn_confirm),
    .ecallData(ecallData), .ecallWrite(ecallWrite), .stall(stall),
    .led_out(led_out), .seg_data(seg_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Value a read service returns: switches as a two's complement number for 5, plain for 12.
  function automatic logic [31:0] read_val(input logic [31:0] svc, input logic [SW-1:0] sw);
    int v;
    v = int'(sw);
    if (svc == 32'd5 && v >= (1 << (SW - 1))) v = v - (1 << SW);
    return 32'(v);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_seg"}, seg_data, m_seg);
    chk({tag, "_led"}, 32'(led_out), m_led);
    chk({tag, "_data"}, ecallData, m_data);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Called on a falling edge with the unit in DISPATCH or WAIT_IN.
  task automatic press_and_write(input logic [31:0] exp_data, input int pend);
    int n, hi;
    btn_confirm = 1'b1;
    n = 0;
    while (!ecallWrite && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("confirm_latency", 32'(n), 32'(SS + 1));
    hi = 0;
    while (ecallWrite && hi < 20) begin
      hi++;
      chk("write_data", ecallData, exp_data);
      chk("write_stall", 32'(stall), 32'd1);
      reg_write_pending = (hi <= pend);
      @(negedge clk);
    end
    reg_write_pending = 1'b0;
    chk("write_len", 32'(hi), 32'(pend + 1));
    chk("release_stall", 32'(stall), 32'd0);
    btn_confirm = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_txn(input logic [31:0] svc, input logic [31:0] arg, input logic [SW-1:0] sw,
                        input int pend, input int wait_c);
    a7 = svc; a0 = arg; sw_in = sw; ecall_req = 1'b1;
    #1 chk("req_stall", 32'(stall), 32'd1);
    @(negedge clk);
    ecall_req = 1'b0; a7 = $urandom; a0 = $urandom;
    chk("disp_stall", 32'(stall), 32'd1);
    chk("disp_nowrite", 32'(ecallWrite), 32'd0);
    if (svc == 32'd5 || svc == 32'd12) begin
      repeat (wait_c) begin
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_nowrite", 32'(ecallWrite), 32'd0);
      end
      press_and_write(m_data, pend);
    end else begin
      @(negedge clk);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_nowrite", 32'(ecallWrite), 32'd0);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_seg = '0; m_led = '0; m_data = '0;
  endtask

  typedef struct {
    logic [31:0]   svc;
    logic [31:0]   arg;
    logic [SW-1:0] sw;
    int            pend;
    logic [31:0]   e_seg;
    logic [31:0]   e_led;
    logic [31:0]   e_data;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{32'd1,     32'hDEADBEEF, 16'h0000, 0, 32'hDEADBEEF, 32'h0,    32'h0};
    tbl[1]  = '{32'd34,    32'h1234ABCD, 16'h0000, 0, 32'hDEADBEEF, 32'hABCD, 32'h0};
    tbl[2]  = '{32'd99,    32'hFFFFFFFF, 16'h0000, 0, 32'hDEADBEEF, 32'hABCD, 32'h0};
    tbl[3]  = '{32'd5,     32'h0,        16'h8001, 0, 32'hDEADBEEF, 32'hABCD, 32'hFFFF8001};
    tbl[4]  = '{32'd12,    32'h0,        16'h8001, 0, 32'hDEADBEEF, 32'hABCD, 32'h00008001};
    tbl[5]  = '{32'd5,     32'h0,        16'h7FFF, 3, 32'hDEADBEEF, 32'hABCD, 32'h00007FFF};
    tbl[6]  = '{32'd12,    32'h0,        16'hFFFF, 1, 32'hDEADBEEF, 32'hABCD, 32'h0000FFFF};
    tbl[7]  = '{32'd5,     32'h0,        16'hFFFF, 0, 32'hDEADBEEF, 32'hABCD, 32'hFFFFFFFF};
    tbl[8]  = '{32'd0,     32'h11111111, 16'h0000, 0, 32'hDEADBEEF, 32'hABCD, 32'hFFFFFFFF};
    tbl[9]  = '{32'h101,   32'h22222222, 16'h0000, 0, 32'hDEADBEEF, 32'hABCD, 32'hFFFFFFFF};
    tbl[10] = '{32'd1,     32'h00000000, 16'h0000, 0, 32'h00000000, 32'hABCD, 32'hFFFFFFFF};

    m_seg = '0; m_led = '0; m_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_write", 32'(ecallWrite), 32'd0);
    check_outputs("rst");
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      m_seg = tbl[i].e_seg; m_led = tbl[i].e_led; m_data = tbl[i].e_data;
      do_txn(tbl[i].svc, tbl[i].arg, tbl[i].sw, tbl[i].pend, i % 3);
      check_outputs("vec");
    end

    // Randomized services against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] svc, arg;
      logic [SW-1:0] sw;
      int pick;
      pick = $urandom_range(0, 5);
      case (pick)
        0: svc = 32'd1;
        1: svc = 32'd34;
        2: svc = 32'd5;
        3: svc = 32'd12;
        4: svc = 32'd99;
        default: svc = $urandom | 32'h100;
      endcase
      arg = $urandom;
      sw = SW'($urandom);
      if (svc == 32'd1)  m_seg = arg;
      if (svc == 32'd34) m_led = 32'(arg[LW-1:0]);
      if (svc == 32'd5 || svc == 32'd12) m_data = read_val(svc, sw);
      do_txn(svc, arg, sw, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      check_outputs("rand");
    end

    // A confirm pulse that arrives while dispatching must not complete the read.
    btn_confirm = 1'b1;
    @(negedge clk);
    a7 = 32'd5; sw_in = 16'h1234; ecall_req = 1'b1;
    @(negedge clk);
    ecall_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("early_nowrite", 32'(ecallWrite), 32'd0);
      chk("early_stall", 32'(stall), 32'd1);
    end
    btn_confirm = 1'b0;
    repeat (3) @(negedge clk);
    m_data = 32'h00001234;
    press_and_write(m_data, 0);
    check_outputs("early");

    // Reset while waiting for the button aborts the read.
    a7 = 32'd12; sw_in = 16'hBEEF; ecall_req = 1'b1;
    @(negedge clk);
    ecall_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_waiting", 32'(stall), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_seg = '0; m_led = '0; m_data = '0;
    chk("midrst_stall", 32'(stall), 32'd0);
    check_outputs("midrst");
    btn_confirm = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_nowrite", 32'(ecallWrite), 32'd0);
    end
    btn_confirm = 1'b0;
    repeat (3) @(negedge clk);

    // Exit halts for good; later ecalls are ignored until reset.
    m_seg = 32'h0BADF00D;
    do_txn(32'd1, 32'h0BADF00D, '0, 0, 0);
    a7 = 32'd10; ecall_req = 1'b1;
    @(negedge clk);
    ecall_req = 1'b0;
    @(negedge clk);
    chk("exit_halted", 32'(halted), 32'd1);
    chk("exit_stall", 32'(stall), 32'd1);
    a7 = 32'd1; a0 = 32'h55555555; ecall_req = 1'b1;
    @(negedge clk);
    ecall_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("halt_stall", 32'(stall), 32'd1);
    chk("halt_seg", seg_data, 32'h0BADF00D);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_nowrite", 32'(ecallWrite), 32'd0);
    do_reset();
    chk("post_exit_halted", 32'(halted), 32'd0);
    chk("post_exit_stall", 32'(stall), 32'd0);
    chk("post_exit_seg", seg_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
